// File: rtl/fir_ctrl_pkg.sv
// Shared constants and types for the FIR coefficient sequencer.
//   DW        sample / coefficient width (two's complement)
//   N_UNIQ    unique coefficients of the symmetric 11-tap FIR
//   LATENCY   FIR valid-pipeline depth, input acceptance to o_valid
//   state_t   sequencer states
//   def_coeff default coefficient for a slot (0 beyond the table)
package fir_ctrl_pkg;

   localparam int DW      = 18;
   localparam int N_UNIQ  = 6;
   localparam int LATENCY = 12;

   localparam int DEF_COEFF [N_UNIQ] = '{88, 0, -97, -197, -294, -380};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      SWAP  = 2'd2
   } state_t;

   function automatic int def_coeff(input int k);
      if (k >= 0 && k < N_UNIQ) return DEF_COEFF[k];
      return 0;
   endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient register banks.
//   clk, reset    clock, async active-high reset (both banks to defaults)
//   wr_en         write shadow[wr_index] with wr_data (index pre-validated)
//   swap          copy the whole shadow bank into the active bank
//   coeff_active  flattened active bank, slot k at [k*DW +: DW]
module fir_coeff_bank #(
   parameter int DW     = fir_ctrl_pkg::DW,
   parameter int N_UNIQ = fir_ctrl_pkg::N_UNIQ,
   parameter int IDXW   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [IDXW-1:0]      wr_index,
   input  logic [DW-1:0]        wr_data,
   input  logic                 swap,
   output logic [N_UNIQ*DW-1:0] coeff_active
);
   import fir_ctrl_pkg::*;

   logic [DW-1:0] shadow [N_UNIQ];
   logic [DW-1:0] active [N_UNIQ];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_UNIQ; k++) begin
            shadow[k] <= DW'(def_coeff(k));
            active[k] <= DW'(def_coeff(k));
         end
      end else begin
         for (int k = 0; k < N_UNIQ; k++) begin
            if (wr_en && wr_index == IDXW'(k)) shadow[k] <= wr_data;
            if (swap) active[k] <= shadow[k];
         end
      end
   end

   for (genvar g = 0; g < N_UNIQ; g++) begin : g_flat
      assign coeff_active[g*DW +: DW] = active[g];
   end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Run-time coefficient controller and sample gatekeeper for the symmetric
// 11-tap FIR. Writes land in a shadow bank; a commit blocks new samples,
// waits LATENCY cycles for in-flight samples to leave the FIR, then swaps
// shadow into active in a single cycle.
//   cfg_valid/cfg_ready/cfg_index/cfg_data  coefficient write port
//   cfg_commit    request to activate the shadow bank (sampled in IDLE)
//   commit_done   one-cycle pulse in SWAP
//   cfg_err       sticky out-of-range write flag, cleared by SWAP
//   busy          high in DRAIN or SWAP
//   s_valid/s_ready/s_data                  upstream sample stream
//   fir_clk_ena, fir_i_valid, fir_i_in      FIR input side
//   coeff_active  active coefficients, slot k at [k*DW +: DW]
//
// state | meaning
// IDLE  | samples and writes accepted, commit sampled
// DRAIN | input held off while FIR pipeline empties (LATENCY cycles)
// SWAP  | shadow copied to active on closing edge, commit_done high
module fir_coeff_sequencer #(
   parameter int DW      = fir_ctrl_pkg::DW,
   parameter int N_UNIQ  = fir_ctrl_pkg::N_UNIQ,
   parameter int IDXW    = 3,
   parameter int LATENCY = fir_ctrl_pkg::LATENCY
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [IDXW-1:0]      cfg_index,
   input  logic [DW-1:0]        cfg_data,
   input  logic                 cfg_commit,
   output logic                 commit_done,
   output logic                 cfg_err,
   output logic                 busy,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DW-1:0]        s_data,
   output logic                 fir_clk_ena,
   output logic                 fir_i_valid,
   output logic [DW-1:0]        fir_i_in,
   output logic [N_UNIQ*DW-1:0] coeff_active
);
   import fir_ctrl_pkg::*;

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [IDXW:0] IDX_LIM = (IDXW+1)'(N_UNIQ);

   state_t        state;
   logic [CW-1:0] drain_cnt;
   logic          cfg_hs;
   logic          idx_ok;
   logic          wr_en;
   logic          swap;

   assign cfg_hs      = cfg_valid & cfg_ready;
   assign idx_ok      = ({1'b0, cfg_index} < IDX_LIM);
   assign wr_en       = cfg_hs & idx_ok;
   assign swap        = (state == SWAP);
   assign fir_i_valid = s_valid & s_ready;
   assign fir_i_in    = s_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         drain_cnt   <= '0;
         s_ready     <= 1'b1;
         cfg_ready   <= 1'b1;
         busy        <= 1'b0;
         commit_done <= 1'b0;
         cfg_err     <= 1'b0;
         fir_clk_ena <= 1'b0;
      end else begin
         fir_clk_ena <= 1'b1;
         commit_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_hs && !idx_ok) cfg_err <= 1'b1;
               if (cfg_commit) begin
                  state     <= DRAIN;
                  drain_cnt <= CW'(LATENCY);
                  s_ready   <= 1'b0;
                  cfg_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - CW'(1);
               // Terminal count 1 so DRAIN spans exactly LATENCY cycles.
               if (drain_cnt == CW'(1)) begin
                  state       <= SWAP;
                  commit_done <= 1'b1;
               end
            end
            SWAP: begin
               state     <= IDLE;
               drain_cnt <= '0;
               cfg_err   <= 1'b0;
               s_ready   <= 1'b1;
               cfg_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   fir_coeff_bank #(
      .DW     (DW),
      .N_UNIQ (N_UNIQ),
      .IDXW   (IDXW)
   ) u_bank (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_index     (cfg_index),
      .wr_data      (cfg_data),
      .swap         (swap),
      .coeff_active (coeff_active)
   );

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed bench for fir_coeff_sequencer with hand-computed expectations.
module tb_fir_coeff_sequencer;

   localparam int DW      = 18;
   localparam int N_UNIQ  = 6;
   localparam int IDXW    = 3;
   localparam int LATENCY = 12;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [IDXW-1:0]      cfg_index;
   logic [DW-1:0]        cfg_data;
   logic                 cfg_commit;
   logic                 commit_done;
   logic                 cfg_err;
   logic                 busy;
   logic                 s_valid;
   logic                 s_ready;
   logic [DW-1:0]        s_data;
   logic                 fir_clk_ena;
   logic                 fir_i_valid;
   logic [DW-1:0]        fir_i_in;
   logic [N_UNIQ*DW-1:0] coeff_active;

   int n_checks = 0;
   int n_errors = 0;
   int n_done;

   // Reference model of the FIR valid pipeline: accepted in cycle t,
   // o_valid in cycle t+LATENCY.
   logic                 acc_n = 1'b0;
   logic [LATENCY-1:0]   pipe  = '0;

   always #5 clk = ~clk;

   always @(negedge clk) acc_n = fir_i_valid;
   always @(posedge clk) pipe <= {pipe[LATENCY-2:0], acc_n};

   fir_coeff_sequencer #(
      .DW (DW), .N_UNIQ (N_UNIQ), .IDXW (IDXW), .LATENCY (LATENCY)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_index    (cfg_index),
      .cfg_data     (cfg_data),
      .cfg_commit   (cfg_commit),
      .commit_done  (commit_done),
      .cfg_err      (cfg_err),
      .busy         (busy),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .fir_clk_ena  (fir_clk_ena),
      .fir_i_valid  (fir_i_valid),
      .fir_i_in     (fir_i_in),
      .coeff_active (coeff_active)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] slot(input int k);
      return 64'(coeff_active[k*DW +: DW]);
   endfunction

   function automatic logic [63:0] ex(input int v);
      logic [DW-1:0] t;
      t = v[DW-1:0];
      return 64'(t);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_defaults(input string tag);
      chk({tag, "_s0"}, slot(0), ex(88));
      chk({tag, "_s1"}, slot(1), ex(0));
      chk({tag, "_s2"}, slot(2), ex(-97));
      chk({tag, "_s3"}, slot(3), ex(-197));
      chk({tag, "_s4"}, slot(4), ex(-294));
      chk({tag, "_s5"}, slot(5), ex(-380));
   endtask

   // Commit in the current cycle, then run through SWAP into IDLE.
   task automatic commit_and_finish();
      cfg_commit = 1'b1;
      #1;
      cyc();
      cfg_commit = 1'b0;
      cfg_valid  = 1'b0;
      for (int n = 2; n <= 14; n++) cyc();
   endtask

   initial begin
      reset      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_index  = '0;
      cfg_data   = '0;
      cfg_commit = 1'b0;
      s_valid    = 1'b1;
      s_data     = 18'h00123;
      cyc();
      cyc();

      // Reset asserted mid-stream
      reset = 1'b1;
      cyc();
      cyc();
      chk("rst_clk_ena", fir_clk_ena, 1'b0);
      chk("rst_s_ready", s_ready, 1'b1);
      chk("rst_cfg_err", cfg_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", commit_done, 1'b0);
      chk_defaults("rst");
      reset = 1'b0;
      cyc();
      chk("clk_ena_after", fir_clk_ena, 1'b1);
      s_data = 18'h2ABCD;
      #1;
      chk("pass_valid", fir_i_valid, 1'b1);
      chk("pass_data", fir_i_in, 64'h2ABCD);

      // Basic commit: slot 0 = 100, commit with s_valid held high
      cfg_valid = 1'b1; cfg_index = 3'd0; cfg_data = 18'd100;
      cyc();
      cfg_valid = 1'b0;
      chk("shadow_hidden", slot(0), ex(88));
      cfg_commit = 1'b1;
      #1;
      chk("t_s_ready", s_ready, 1'b1);
      chk("t_i_valid", fir_i_valid, 1'b1);
      for (int n = 1; n <= 14; n++) begin
         cyc();
         cfg_commit = 1'b0;
         chk("bc_s_ready", s_ready, 64'(n == 14));
         chk("bc_done", commit_done, 64'(n == 13));
         chk("bc_busy", busy, 64'(n <= 13));
         if (n <= 13) chk("bc_i_valid", fir_i_valid, 1'b0);
         if (n == 12) chk("bc_last_ovalid", pipe[LATENCY-1], 1'b1);
         if (n == 13) begin
            chk("bc_pipe_empty", 64'(pipe == '0), 1'b1);
            chk("bc_old_s0", slot(0), ex(88));
         end
         if (n == 14) chk("bc_new_s0", slot(0), ex(100));
      end

      // Simultaneous write, commit and sample
      cfg_valid = 1'b1; cfg_index = 3'd5; cfg_data = 18'd7;
      s_data = 18'h00155;
      cfg_commit = 1'b1;
      #1;
      chk("sim_cfg_ready", cfg_ready, 1'b1);
      chk("sim_i_valid", fir_i_valid, 1'b1);
      chk("sim_i_in", fir_i_in, 64'h155);
      cyc();
      cfg_commit = 1'b0;
      cfg_valid  = 1'b0;
      for (int n = 2; n <= 14; n++) begin
         cyc();
         if (n == 13) chk("sim_done", commit_done, 1'b1);
      end
      chk("sim_s5", slot(5), ex(7));
      chk("sim_s0", slot(0), ex(100));

      // Out-of-range write
      cfg_valid = 1'b1; cfg_index = 3'd6; cfg_data = 18'h3FFFF;
      cyc();
      cfg_valid = 1'b0;
      chk("oor_err", cfg_err, 1'b1);
      cfg_commit = 1'b1;
      #1;
      cyc();
      cfg_commit = 1'b0;
      for (int n = 2; n <= 14; n++) begin
         cyc();
         if (n == 13) chk("oor_err_drain", cfg_err, 1'b1);
      end
      chk("oor_err_clr", cfg_err, 1'b0);
      chk("oor_s0", slot(0), ex(100));
      chk("oor_s1", slot(1), ex(0));
      chk("oor_s5", slot(5), ex(7));

      // Busy: writes and commits during DRAIN are ignored
      n_done = 0;
      cfg_commit = 1'b1;
      #1;
      cyc();
      cfg_commit = 1'b0;
      for (int n = 2; n <= 30; n++) begin
         if (n >= 3 && n <= 6) begin
            cfg_valid = 1'b1; cfg_index = 3'd2; cfg_data = 18'd999;
            cfg_commit = 1'b1;
            #1;
            chk("busy_cfg_ready", cfg_ready, 1'b0);
         end else begin
            cfg_valid = 1'b0; cfg_commit = 1'b0;
         end
         cyc();
         if (commit_done) n_done++;
      end
      chk("busy_one_done", 64'(n_done), 64'd1);
      chk("busy_idle", busy, 1'b0);
      commit_and_finish();
      chk("busy_s2", slot(2), ex(-97));

      // Reset at DRAIN cycle 5
      cfg_valid = 1'b1; cfg_index = 3'd3; cfg_data = 18'd1234;
      cyc();
      cfg_valid = 1'b0;
      cfg_commit = 1'b1;
      #1;
      n_done = 0;
      for (int n = 1; n <= 5; n++) begin
         cyc();
         cfg_commit = 1'b0;
         if (commit_done) n_done++;
      end
      chk("rd_busy_pre", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk("rd_busy", busy, 1'b0);
      chk("rd_s_ready", s_ready, 1'b1);
      chk("rd_s0", slot(0), ex(88));
      chk("rd_s5", slot(5), ex(-380));
      cyc();
      reset = 1'b0;
      for (int n = 0; n < 20; n++) begin
         cyc();
         if (commit_done) n_done++;
      end
      chk("rd_no_done", 64'(n_done), 64'd0);
      chk("rd_idle", busy, 1'b0);
      commit_and_finish();
      chk_defaults("rd_after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fir_coeff_sequencer.md
# fir_coeff_sequencer

Run-time coefficient controller and input gatekeeper for the symmetric 11-tap FIR. It accepts coefficient writes into a shadow bank while samples keep streaming. On a commit request it stops new samples, waits until every in-flight sample has produced its output, then swaps the shadow bank into the active bank in one cycle. This guarantees no FIR output is ever computed with a mix of old and new coefficients. It sits between the sample source and host configuration port on one side and the FIR's `i_valid`/`i_in`/`clk_ena`/coefficient inputs on the other.

## Interface
Parameters:
- `DW`, 18: sample and coefficient width, two's complement.
- `N_UNIQ`, 6: number of unique coefficients, ceil(11/2).
- `IDXW`, 3: coefficient index width; must satisfy 2^IDXW ≥ N_UNIQ.
- `LATENCY`, 12: FIR valid-pipeline depth, i.e. cycles from input acceptance to `o_valid`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  coefficient write request.
- `cfg_ready`  out  1  write accepted this cycle when high together with `cfg_valid`.
- `cfg_index`  in  IDXW  coefficient slot to write.
- `cfg_data`  in  DW  coefficient value.
- `cfg_commit`  in  1  single-cycle request to activate the shadow bank.
- `commit_done`  out  1  one-cycle pulse in the SWAP cycle.
- `cfg_err`  out  1  sticky flag: an out-of-range write occurred.
- `busy`  out  1  high in DRAIN or SWAP.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  sample accepted when high together with `s_valid`.
- `s_data`  in  DW  upstream sample.
- `fir_clk_ena`  out  1  FIR clock enable.
- `fir_i_valid`  out  1  FIR input valid.
- `fir_i_in`  out  DW  FIR input sample.
- `coeff_active`  out  N_UNIQ*DW  active coefficients; slot k occupies bits [k*DW +: DW].

## Operation
- **States:** IDLE, DRAIN, SWAP. Reset enters IDLE.
- **Outputs by state:**
  - `s_ready` = 1 only in IDLE; it depends only on state, not on `s_valid`.
  - `cfg_ready` = 1 only in IDLE.
  - `fir_i_valid` = `s_valid & s_ready`.
  - `fir_i_in` = `s_data`, combinational pass-through.
  - `fir_clk_ena` is registered: 0 in reset, 1 thereafter in all states.
- **Coefficient writes (IDLE only):**
  - A handshake with `cfg_index` < N_UNIQ writes `shadow[cfg_index]`.
  - A handshake with `cfg_index` ≥ N_UNIQ is consumed, discarded, and sets `cfg_err`.
- **Commit:**
  - `cfg_commit` is sampled only in IDLE. In DRAIN or SWAP it is ignored and no pending commit is recorded.
  - On a sampled commit: next state DRAIN, drain counter loaded with LATENCY.
  - A write handshake in the same cycle as the commit lands in the shadow bank before the swap.
  - A sample handshake in the same cycle is the last sample accepted under the old bank.
- **DRAIN:**
  - Counter decrements each cycle.
  - When the counter reaches 1, the next state is SWAP, so DRAIN lasts exactly LATENCY cycles.
  - `s_valid` is held off because `s_ready` = 0.
- **SWAP (one cycle):**
  - `commit_done` = 1.
  - `active` <= `shadow` on the closing edge.
  - `cfg_err` is cleared on that edge.
  - Next state IDLE.
- **Reset values:**
  - Shadow and active banks hold the package defaults: 88, 0, -97, -197, -294, -380.
  - `cfg_err` = 0, `commit_done` = 0, `busy` = 0, counter = 0.
- **Reset mid-DRAIN:** return to IDLE with default banks. No `commit_done` is issued.

## Timing
- Commit sampled in cycle t:
  - DRAIN occupies cycles t+1 … t+LATENCY.
  - SWAP is cycle t+LATENCY+1.
  - New `coeff_active` is visible from cycle t+LATENCY+2.
  - `s_ready` is high again in cycle t+LATENCY+2.
- A sample accepted in cycle t produces FIR `o_valid` in cycle t+LATENCY, which is before SWAP.
- Stream stall per commit is LATENCY+1 cycles.
- Write-to-shadow latency is 1 edge. Shadow contents are never visible on `coeff_active` before SWAP.
- Back-to-back commits: a second commit is honoured only once IDLE is re-entered.

## Structure
- Package `fir_ctrl_pkg` holds:
  - DW, N_UNIQ, LATENCY;
  - the default coefficient constants;
  - the state enum {IDLE, DRAIN, SWAP}.
- Sub-module `fir_coeff_bank` holds the shadow and active register arrays. Its inputs are a write port, a swap strobe and reset-to-defaults; its output is the flattened active bank.
- The top level holds the FSM, drain counter, handshakes and error flag.

## Test plan
- **Reset:** assert `reset` mid-stream → `coeff_active` = {88, 0, -97, -197, -294, -380}, `s_ready` = 1, `cfg_err` = 0, `fir_clk_ena` = 0 until release.
- **Basic commit:** write slot 0 = 100, then commit in cycle t with `s_valid` held high.
  - `s_ready` falls at t+1.
  - `commit_done` pulses at t+13.
  - `coeff_active[0]` = 100 at t+14; `s_ready` = 1 at t+14.
  - The last old-bank `o_valid` appears at t+12.
- **Simultaneous write, commit and sample:** write slot 5 = 7 together with commit and a sample handshake → slot 5 = 7 is active after the swap, and the sample passes to `fir_i_valid` that cycle.
- **Out-of-range write:** write with `cfg_index` = 6 → no slot changes, `cfg_err` = 1, cleared in the next SWAP.
- **Busy behaviour:** assert `cfg_valid` and `cfg_commit` during DRAIN → `cfg_ready` = 0, no second `commit_done`, shadow unchanged.
- **Reset at DRAIN cycle 5:** `commit_done` never pulses, banks return to defaults, state is IDLE.
